// File: rtl/config_sequencer.sv
// Configuration bitstream loader: header word, N (addr, data) payload words and an
// XOR checksum word; each payload word is replayed onto the tile config bus.
module config_sequencer #(
    parameter int HOLD_CYCLES = 2,
    parameter int MAX_WORDS   = 1024,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [31:0]          i_in_addr,
    input  logic [31:0]          i_in_data,
    output logic [31:0]          o_config_addr,
    output logic [31:0]          o_config_data,
    output logic                 o_config_write,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [CNT_WIDTH-1:0] o_words_loaded
);

    localparam int                   HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] MAX_N     = CNT_WIDTH'(MAX_WORDS);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_ACCEPT,
        S_HOLD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_WIDTH-1:0] r_remaining;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [31:0]          r_checksum;
    logic [31:0]          r_config_addr;
    logic [31:0]          r_config_data;
    logic                 r_config_write;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic [CNT_WIDTH-1:0] r_words_loaded;

    logic                 w_take;
    logic [CNT_WIDTH-1:0] w_hdr_n;
    logic                 w_hdr_bad;
    logic                 w_start_load;
    logic                 w_hold_last;

    // in_ready is decoded straight from state so the producer sees it in the same
    // cycle the state changes; every other output comes from a register.
    assign o_in_ready   = (r_state == S_HEADER) || (r_state == S_ACCEPT) || (r_state == S_CHECK);
    assign w_take       = i_in_valid && o_in_ready;
    assign w_hdr_n      = i_in_data[CNT_WIDTH-1:0];
    assign w_hdr_bad    = (w_hdr_n > MAX_N);
    assign w_start_load = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_hold_last  = (r_hold_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of block ordering.
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default first; without it a path that skips the assignment infers a latch.
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_HEADER;
            S_HEADER: begin
                if (w_take) begin
                    if (w_hdr_bad)           w_next = S_DONE;
                    else if (w_hdr_n == '0)  w_next = S_CHECK;
                    else                     w_next = S_ACCEPT;
                end
            end
            S_ACCEPT: if (w_take) w_next = S_HOLD;
            S_HOLD: begin
                if (w_hold_last)
                    w_next = (r_remaining == CNT_WIDTH'(1)) ? S_CHECK : S_ACCEPT;
            end
            S_CHECK:  if (w_take) w_next = S_DONE;
            S_DONE:   if (i_start) w_next = S_HEADER;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining    <= '0;
            r_hold_cnt     <= '0;
            r_checksum     <= '0;
            r_config_addr  <= '0;
            r_config_data  <= '0;
            r_config_write <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
        end else begin
            // busy/done are registered from the next state so they line up with r_state.
            r_busy <= (w_next == S_HEADER) || (w_next == S_ACCEPT) ||
                      (w_next == S_HOLD)   || (w_next == S_CHECK);
            r_done <= (w_next == S_DONE);

            if (w_start_load) begin
                r_error        <= 1'b0;
                r_words_loaded <= '0;
                r_checksum     <= '0;
            end

            case (r_state)
                S_HEADER: begin
                    if (w_take) begin
                        r_remaining <= w_hdr_n;
                        if (w_hdr_bad) r_error <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (w_take) begin
                        r_config_addr  <= i_in_addr;
                        r_config_data  <= i_in_data;
                        r_checksum     <= r_checksum ^ i_in_data;
                        r_config_write <= 1'b1;
                        r_hold_cnt     <= HOLD_LOAD;
                    end
                end
                S_HOLD: begin
                    if (w_hold_last) begin
                        r_config_write <= 1'b0;
                        r_remaining    <= r_remaining - CNT_WIDTH'(1);
                        if (r_words_loaded != CNT_SAT)
                            r_words_loaded <= r_words_loaded + CNT_WIDTH'(1);
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_take) r_error <= (i_in_data != r_checksum);
                end
                default: ;
            endcase
        end
    end

    assign o_config_addr  = r_config_addr;
    assign o_config_data  = r_config_data;
    assign o_config_write = r_config_write;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_config_sequencer.sv
// Scoreboard bench: instance 0 uses HOLD_CYCLES=2, instance 1 uses HOLD_CYCLES=3.
module tb_config_sequencer;

    localparam int MAX_WORDS = 1024;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        err;
        logic [15:0] words;
    } dn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst;
    logic [1:0]        start;
    logic [1:0]        valid;
    logic [1:0]        ready;
    logic [1:0][31:0]  in_addr;
    logic [1:0][31:0]  in_data;
    logic [1:0][31:0]  cfg_addr;
    logic [1:0][31:0]  cfg_data;
    logic [1:0]        cw;
    logic [1:0]        busy;
    logic [1:0]        done;
    logic [1:0]        err;
    logic [1:0][15:0]  words;

    int n_cmp  = 0;
    int n_fail = 0;

    wr_t exp_wr_q[2][$];
    dn_t exp_dn_q[2][$];

    config_sequencer #(.HOLD_CYCLES(2), .MAX_WORDS(MAX_WORDS), .CNT_WIDTH(16)) u_dut0 (
        .clk(clk), .reset(rst[0]), .i_start(start[0]), .i_in_valid(valid[0]),
        .o_in_ready(ready[0]), .i_in_addr(in_addr[0]), .i_in_data(in_data[0]),
        .o_config_addr(cfg_addr[0]), .o_config_data(cfg_data[0]),
        .o_config_write(cw[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_error(err[0]), .o_words_loaded(words[0])
    );

    config_sequencer #(.HOLD_CYCLES(3), .MAX_WORDS(MAX_WORDS), .CNT_WIDTH(16)) u_dut1 (
        .clk(clk), .reset(rst[1]), .i_start(start[1]), .i_in_valid(valid[1]),
        .o_in_ready(ready[1]), .i_in_addr(in_addr[1]), .i_in_data(in_data[1]),
        .o_config_addr(cfg_addr[1]), .o_config_data(cfg_data[1]),
        .o_config_write(cw[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_error(err[1]), .o_words_loaded(words[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: compare each write pulse, in_ready gap and done event with the queues.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int HC = (g == 0) ? 2 : 3;
        bit  prev_cw   = 1'b0;
        bit  prev_done = 1'b0;
        int  len       = 0;
        int  rdy_run   = 0;
        wr_t cur;
        dn_t dn;

        always @(negedge clk) begin
            bit cw_now;
            bit done_now;
            cw_now   = (cw[g] === 1'b1);
            done_now = (done[g] === 1'b1);

            if (cw_now && !prev_cw) begin
                len = 1;
                if (exp_wr_q[g].size() == 0) begin
                    check($sformatf("unexpected_write_%0d", g), cw[g], 1'b0);
                    cur = '{addr: cfg_addr[g], data: cfg_data[g]};
                end else begin
                    cur = exp_wr_q[g].pop_front();
                    check($sformatf("wr_addr_%0d", g), cfg_addr[g], cur.addr);
                    check($sformatf("wr_data_%0d", g), cfg_data[g], cur.data);
                end
            end else if (cw_now) begin
                len++;
            end else if (prev_cw && rst[g] !== 1'b1) begin
                check($sformatf("wr_pulse_len_%0d", g), len, HC);
                check($sformatf("wr_addr_kept_%0d", g), cfg_addr[g], cur.addr);
                check($sformatf("wr_data_kept_%0d", g), cfg_data[g], cur.data);
            end
            prev_cw = cw_now;

            if (busy[g] !== 1'b1) begin
                rdy_run = 0;
            end else if (ready[g] !== 1'b1) begin
                rdy_run++;
            end else begin
                if (rdy_run != 0) check($sformatf("ready_gap_%0d", g), rdy_run, HC);
                rdy_run = 0;
            end

            if (done_now && !prev_done) begin
                if (exp_dn_q[g].size() == 0) begin
                    check($sformatf("unexpected_done_%0d", g), done[g], 1'b0);
                end else begin
                    dn = exp_dn_q[g].pop_front();
                    check($sformatf("done_error_%0d", g), err[g], dn.err);
                    check($sformatf("done_words_%0d", g), words[g], dn.words);
                end
            end
            prev_done = done_now;
        end
    end

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [31:0] a, input logic [31:0] dt, input bit keep);
        int waited;
        waited     = 0;
        valid[d]   = 1'b1;
        in_addr[d] = a;
        in_data[d] = dt;
        @(negedge clk);
        while (ready[d] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (ready[d] !== 1'b1) check($sformatf("ready_timeout_%0d", d), ready[d], 1'b1);
        else begin
            @(posedge clk); #1;
        end
        if (!keep) valid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int waited;
        waited = 0;
        while (done[d] !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (done[d] !== 1'b1) check($sformatf("done_timeout_%0d", d), done[d], 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic run_load(input int d, input logic [31:0] hdr, input int n,
                            input logic [31:0] addrs[4], input logic [31:0] datas[4],
                            input logic [31:0] cks, input logic exp_err,
                            input int exp_words, input bit keep);
        pulse_start(d);
        if (hdr > MAX_WORDS) begin
            exp_dn_q[d].push_back('{err: exp_err, words: 16'(exp_words)});
            send(d, 32'h0, hdr, 1'b0);
            check($sformatf("bad_hdr_done_%0d", d), done[d], 1'b1);
            check($sformatf("bad_hdr_error_%0d", d), err[d], 1'b1);
            check($sformatf("bad_hdr_no_write_%0d", d), cw[d], 1'b0);
        end else begin
            send(d, 32'h0, hdr, keep);
            for (int i = 0; i < n; i++) begin
                send(d, addrs[i], datas[i], keep);
                exp_wr_q[d].push_back('{addr: addrs[i], data: datas[i]});
            end
            exp_dn_q[d].push_back('{err: exp_err, words: 16'(exp_words)});
            send(d, 32'h0, cks, 1'b0);
        end
        valid[d] = 1'b0;
        wait_done(d);
    endtask

    task automatic check_reset_values(input int d, input string tag);
        check($sformatf("%s_ready_%0d", tag, d), ready[d], 1'b0);
        check($sformatf("%s_cw_%0d", tag, d), cw[d], 1'b0);
        check($sformatf("%s_busy_%0d", tag, d), busy[d], 1'b0);
        check($sformatf("%s_done_%0d", tag, d), done[d], 1'b0);
        check($sformatf("%s_error_%0d", tag, d), err[d], 1'b0);
        check($sformatf("%s_addr_%0d", tag, d), cfg_addr[d], 32'h0);
        check($sformatf("%s_data_%0d", tag, d), cfg_data[d], 32'h0);
        check($sformatf("%s_words_%0d", tag, d), words[d], 16'h0);
    endtask

    logic [31:0] va[4];
    logic [31:0] vd[4];

    initial begin
        rst     = 2'b11;
        start   = '0;
        valid   = '0;
        in_addr = '0;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values(0, "rst");
        check_reset_values(1, "rst");
        rst = 2'b00;

        // Two-word load, good checksum (0xA ^ 0x5 = 0xF), then bad checksum 0xE.
        va = '{32'h10, 32'h20, 32'h0, 32'h0};
        vd = '{32'hA, 32'h5, 32'h0, 32'h0};
        run_load(0, 32'd2, 2, va, vd, 32'hF, 1'b0, 2, 1'b0);
        run_load(0, 32'd2, 2, va, vd, 32'hE, 1'b1, 2, 1'b0);

        // Oversized header, then empty payloads with good and bad checksums.
        run_load(0, MAX_WORDS + 1, 0, va, vd, 32'h0, 1'b1, 0, 1'b0);
        run_load(0, 32'd0, 0, va, vd, 32'h0, 1'b0, 0, 1'b0);
        run_load(0, 32'd0, 0, va, vd, 32'h1, 1'b1, 0, 1'b0);

        // HOLD_CYCLES=3 instance with in_valid held high: 0x11^0x22^0x44^0x88 = 0xFF.
        va = '{32'h100, 32'h104, 32'h108, 32'h10C};
        vd = '{32'h11, 32'h22, 32'h44, 32'h88};
        run_load(1, 32'd4, 4, va, vd, 32'hFF, 1'b0, 4, 1'b1);

        // Reset during the HOLD of word 2 of 4 aborts the load immediately.
        pulse_start(0);
        send(0, 32'h0, 32'd4, 1'b0);
        send(0, 32'h30, 32'h1, 1'b0);
        exp_wr_q[0].push_back('{addr: 32'h30, data: 32'h1});
        send(0, 32'h34, 32'h2, 1'b0);
        exp_wr_q[0].push_back('{addr: 32'h34, data: 32'h2});
        rst[0] = 1'b1;
        @(posedge clk); #1;
        check_reset_values(0, "midload_rst");
        @(posedge clk); #1;
        rst[0] = 1'b0;

        va = '{32'h40, 32'h44, 32'h0, 32'h0};
        vd = '{32'h0F0, 32'h00F, 32'h0, 32'h0};
        run_load(0, 32'd2, 2, va, vd, 32'h0FF, 1'b0, 2, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("wr_queue_empty_0", exp_wr_q[0].size(), 0);
        check("wr_queue_empty_1", exp_wr_q[1].size(), 0);
        check("done_queue_empty_0", exp_dn_q[0].size(), 0);
        check("done_queue_empty_1", exp_dn_q[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
